keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_pkg.sv | 29 ++
 rtl/sync_2ff.sv | 24 ++
 rtl/keypad_scan.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the 4x4 keypad scanner: FSM states, key map and defaults.
package keypad_pkg;

  localparam int DEF_ROW_CYCLES     = 100000;
  localparam int DEF_DEBOUNCE_SCANS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEBOUNCE,
    ST_HELD,
    ST_RELEASE
  } state_t;

  // Indexed by {row, col}; row0 = 1 2 3 A, row1 = 4 5 6 B, row2 = 7 8 9 C, row3 = 0 F E D
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hE, 4'hF, 4'h0,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  // Shift a newly accepted code into the history; a coincident clear drops the old codes
  function automatic logic [15:0] push_code(input logic [15:0] hist,
                                            input logic [3:0]  code,
                                            input logic        clr);
    return clr ? {12'h000, code} : {hist[11:0], code};
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous, active-low inputs; resets to the released level.
module sync_2ff #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two-stage capture so metastability settles before the value is used
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= '1;
      q    <= '1;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: drives one row low at a time, classifies each full scan
// and debounces presses and releases over several consecutive scans.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int ROW_CYCLES     = DEF_ROW_CYCLES,
  parameter int DEBOUNCE_SCANS = DEF_DEBOUNCE_SCANS
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col,
  input  logic        clear,
  output logic [3:0]  row,
  output logic [15:0] value,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held
);

  localparam int RCW = (ROW_CYCLES > 1) ? $clog2(ROW_CYCLES) : 1;
  localparam int DCW = $clog2(DEBOUNCE_SCANS + 1);

  logic [3:0]     col_s;
  logic [RCW-1:0] cyc_cnt;
  logic [1:0]     row_idx;
  logic           sample;
  logic           scan_done;

  logic [1:0]     acc_cnt;
  logic [3:0]     acc_code;
  logic [2:0]     row_hits;
  logic [3:0]     row_key;
  logic [2:0]     scan_hits;
  logic [3:0]     scan_code;
  logic           scan_none;
  logic           scan_single;

  state_t         state;
  logic [3:0]     cand;
  logic [DCW-1:0] deb_cnt;

  sync_2ff #(.WIDTH(4)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col),
    .q   (col_s)
  );

  assign sample    = (cyc_cnt == RCW'(ROW_CYCLES - 1));
  assign scan_done = sample && (row_idx == 2'd3);
  assign row       = ~(4'b0001 << row_idx);

  // Row timer: each row is driven for ROW_CYCLES cycles, then the next row takes over
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_cnt <= '0;
      row_idx <= 2'd0;
    end else if (sample) begin
      cyc_cnt <= '0;
      row_idx <= row_idx + 2'd1;
    end else begin
      cyc_cnt <= cyc_cnt + RCW'(1);
    end
  end

  // Count pressed columns on the current row and fold them into this scan's running totals
  always_comb begin
    row_hits = '0;
    row_key  = '0;
    for (int c = 0; c < 4; c++) begin
      if (!col_s[c]) begin
        row_hits = row_hits + 3'd1;
        row_key  = KEY_MAP[{row_idx, 2'(c)}];
      end
    end
    scan_hits   = {1'b0, acc_cnt} + row_hits;
    scan_code   = (row_hits != 3'd0) ? row_key : acc_code;
    scan_none   = (scan_hits == 3'd0);
    scan_single = (scan_hits == 3'd1);
  end

  // Per-scan accumulator: saturates at two keys, cleared when a scan completes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_cnt  <= 2'd0;
      acc_code <= 4'd0;
    end else if (sample) begin
      if (row_idx == 2'd3) begin
        acc_cnt  <= 2'd0;
        acc_code <= 4'd0;
      end else begin
        acc_cnt  <= (scan_hits >= 3'd2) ? 2'd2 : scan_hits[1:0];
        acc_code <= scan_code;
      end
    end
  end

  // Debounce FSM: steps once per completed scan and owns every registered output
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      cand      <= 4'd0;
      deb_cnt   <= '0;
      key_valid <= 1'b0;
      key_code  <= 4'd0;
      value     <= 16'h0000;
      key_held  <= 1'b0;
    end else begin
      key_valid <= 1'b0;
      if (clear) begin
        value <= 16'h0000;
      end
      if (scan_done) begin
        case (state)
          ST_IDLE: begin
            if (scan_single) begin
              cand    <= scan_code;
              deb_cnt <= DCW'(1);
              if (DEBOUNCE_SCANS == 1) begin
                state     <= ST_HELD;
                key_valid <= 1'b1;
                key_code  <= scan_code;
                value     <= push_code(value, scan_code, clear);
                key_held  <= 1'b1;
              end else begin
                state <= ST_DEBOUNCE;
              end
            end
          end
          ST_DEBOUNCE: begin
            if (scan_single && (scan_code == cand)) begin
              if ((deb_cnt + DCW'(1)) == DCW'(DEBOUNCE_SCANS)) begin
                state     <= ST_HELD;
                key_valid <= 1'b1;
                key_code  <= cand;
                value     <= push_code(value, cand, clear);
                key_held  <= 1'b1;
              end else begin
                deb_cnt <= deb_cnt + DCW'(1);
              end
            end else if (scan_single) begin
              cand    <= scan_code;
              deb_cnt <= DCW'(1);
            end else begin
              state <= ST_IDLE;
            end
          end
          ST_HELD: begin
            if (scan_none) begin
              key_held <= 1'b0;
              deb_cnt  <= DCW'(1);
              state    <= (DEBOUNCE_SCANS == 1) ? ST_IDLE : ST_RELEASE;
            end
          end
          ST_RELEASE: begin
            if (scan_none) begin
              if ((deb_cnt + DCW'(1)) == DCW'(DEBOUNCE_SCANS)) begin
                state <= ST_IDLE;
              end else begin
                deb_cnt <= deb_cnt + DCW'(1);
              end
            end else begin
              state    <= ST_HELD;
              key_held <= 1'b1;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule
